// File: rtl/mobius_pkg.sv
// Shared types and elaboration helpers for the binary Mobius transform controller.
package mobius_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // The round counter must reach LOG2_N itself, not just LOG2_N-1.
    function automatic int round_width(input int log2_n);
        return $clog2(log2_n + 1);
    endfunction

    function automatic bit mobius_legal(input int n, input int log2_n);
        return (n >= 2) && ((n & (n - 1)) == 0) && ((1 << log2_n) == n);
    endfunction

endpackage

// File: rtl/mobius_round.sv
// One Mobius round: butterfly (upper half ^= lower half) then perfect shuffle.
module mobius_round #(
    parameter int N = 2048
) (
    input  logic [N-1:0] x,
    output logic [N-1:0] y
);

    localparam int H = N / 2;

    logic [N-1:0] m;

    for (genvar i = 0; i < H; i++) begin : g_lane
        assign m[i]       = x[i];
        assign m[i+H]     = x[i+H] ^ x[i];
        assign y[2*i]     = m[i];
        assign y[2*i+1]   = m[i+H];
    end

endmodule

// File: rtl/mobius_ctrl.sv
// Restartable, abortable IDLE/RUN/DONE sequencer applying LOG2_N Mobius rounds to one vector.
module mobius_ctrl
    import mobius_pkg::*;
#(
    parameter int N      = 2048,
    parameter int LOG2_N = 11
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N-1:0]                    in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            abort,
    output logic [N-1:0]                    out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic [round_width(LOG2_N)-1:0]  round
);

    localparam int RW = round_width(LOG2_N);
    localparam logic [RW-1:0] LAST_ROUND = RW'(LOG2_N - 1);

    if (!mobius_legal(N, LOG2_N)) begin : g_bad_params
        $error("mobius_ctrl: N must be a power of two >= 2 and LOG2_N must equal log2(N)");
    end

    state_t          state_p0, state_nxt;
    logic [N-1:0]    data_p0, data_nxt, rnd_out;
    logic [RW-1:0]   round_p0, round_nxt;

    mobius_round #(.N(N)) u_round (
        .x (data_p0),
        .y (rnd_out)
    );

    always_comb begin
        state_nxt = state_p0;
        data_nxt  = data_p0;
        round_nxt = round_p0;
        if (abort) begin
            // Abort beats every normal transition, including an IDLE accept.
            state_nxt = IDLE;
        end else begin
            case (state_p0)
                IDLE: begin
                    if (in_valid) begin
                        data_nxt  = in_data;
                        round_nxt = '0;
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    data_nxt  = rnd_out;
                    round_nxt = round_p0 + RW'(1);
                    if (round_p0 == LAST_ROUND) state_nxt = DONE;
                end
                DONE: begin
                    if (out_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---- register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
            data_p0  <= '0;
            round_p0 <= '0;
        end else begin
            state_p0 <= state_nxt;
            data_p0  <= data_nxt;
            round_p0 <= round_nxt;
        end
    end

    assign in_ready  = (state_p0 == IDLE);
    assign out_valid = (state_p0 == DONE);
    assign busy      = (state_p0 == RUN);
    assign out_data  = data_p0;
    assign round     = round_p0;

endmodule

// File: tb/tb_mobius_ctrl.sv
// Directed bench for mobius_ctrl at N=4, N=8 and N=2048 (bit i of a vector is element i).
module tb_mobius_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // N = 4
    logic [3:0] in4, od4;
    logic iv4, ir4, ab4, ov4, ordy4, busy4;
    logic [1:0] rnd4;
    // N = 8
    logic [7:0] in8, od8;
    logic iv8, ir8, ab8, ov8, ordy8, busy8;
    logic [1:0] rnd8;
    // N = 2048
    logic [2047:0] in2k, od2k;
    logic iv2k, ir2k, ab2k, ov2k, ordy2k, busy2k;
    logic [3:0] rnd2k;

    mobius_ctrl #(.N(4), .LOG2_N(2)) u4 (
        .clk(clk), .rst(rst), .in_data(in4), .in_valid(iv4), .in_ready(ir4), .abort(ab4),
        .out_data(od4), .out_valid(ov4), .out_ready(ordy4), .busy(busy4), .round(rnd4));
    mobius_ctrl #(.N(8), .LOG2_N(3)) u8 (
        .clk(clk), .rst(rst), .in_data(in8), .in_valid(iv8), .in_ready(ir8), .abort(ab8),
        .out_data(od8), .out_valid(ov8), .out_ready(ordy8), .busy(busy8), .round(rnd8));
    mobius_ctrl #(.N(2048), .LOG2_N(11)) u2k (
        .clk(clk), .rst(rst), .in_data(in2k), .in_valid(iv2k), .in_ready(ir2k), .abort(ab2k),
        .out_data(od2k), .out_valid(ov2k), .out_ready(ordy2k), .busy(busy2k), .round(rnd2k));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed low64 %h expected low64 %h (%0d bits differ)",
                   tag, obs[63:0], exp[63:0], $countones(obs ^ exp));
        end
    endtask

    // Independent reference: in-place subset-XOR Mobius transform.
    function automatic logic [2047:0] mref(input logic [2047:0] x);
        logic [2047:0] y;
        y = x;
        for (int b = 0; b < 11; b++)
            for (int j = 0; j < 2048; j++)
                if (((j >> b) & 1) == 1) y[j] = y[j] ^ y[j ^ (1 << b)];
        return y;
    endfunction

    task automatic job4(input logic [3:0] v, input logic [3:0] exp, input string tag);
        in4 = v; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        chk({tag, "_busy"}, 64'(busy4), 64'd1);
        tick();
        chk({tag, "_ov_early"}, 64'(ov4), 64'd0);
        tick();
        chk({tag, "_ov"}, 64'(ov4), 64'd1);
        chk({tag, "_data"}, 64'(od4), 64'(exp));
        ordy4 = 1'b1;
        tick();
        ordy4 = 1'b0;
        chk({tag, "_release"}, 64'(ir4), 64'd1);
    endtask

    task automatic job8(input logic [7:0] v, input logic [7:0] exp, input string tag);
        in8 = v; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        chk({tag, "_r0"}, 64'(rnd8), 64'd0);
        tick();
        chk({tag, "_r1"}, 64'(rnd8), 64'd1);
        tick();
        chk({tag, "_r2"}, 64'(rnd8), 64'd2);
        chk({tag, "_ov_early"}, 64'(ov8), 64'd0);
        tick();
        chk({tag, "_r3"}, 64'(rnd8), 64'd3);
        chk({tag, "_ov"}, 64'(ov8), 64'd1);
        chk({tag, "_data"}, 64'(od8), 64'(exp));
        ordy8 = 1'b1;
        tick();
        ordy8 = 1'b0;
        chk({tag, "_release"}, 64'(ir8), 64'd1);
    endtask

    task automatic job2k(input logic [2047:0] v, input logic [2047:0] exp, input string tag);
        in2k = v; iv2k = 1'b1;
        tick();
        iv2k = 1'b0;
        repeat (10) tick();
        chk({tag, "_ov_early"}, 64'(ov2k), 64'd0);
        tick();
        chk({tag, "_ov"}, 64'(ov2k), 64'd1);
        chk({tag, "_round"}, 64'(rnd2k), 64'd11);
        chk_w({tag, "_data"}, od2k, exp);
        ordy2k = 1'b1;
        tick();
        ordy2k = 1'b0;
    endtask

    initial begin
        logic [2047:0] v, r;
        int acc_t[$];
        int cyc;
        logic acc;

        rst = 1'b1;
        in4 = '0; iv4 = 0; ab4 = 0; ordy4 = 0;
        in8 = '0; iv8 = 0; ab8 = 0; ordy8 = 0;
        in2k = '0; iv2k = 0; ab2k = 0; ordy2k = 0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_in_ready", 64'(ir8), 64'd1);
        chk("rst_out_valid", 64'(ov8), 64'd0);
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_round", 64'(rnd8), 64'd0);
        chk("rst_data", 64'(od8), 64'd0);
        chk("rst_data2k_low", 64'(od2k[63:0]), 64'd0);

        // N=4: element 0 alone spreads to every element; element 1 to elements 1 and 3.
        job4(4'b0001, 4'b1111, "n4_e0");
        job4(4'b0010, 4'b1010, "n4_e1");

        // N=8: element 0 -> all ones; element 7 maps to itself.
        job8(8'h01, 8'hFF, "n8_e0");
        job8(8'h80, 8'h80, "n8_e7");

        // Backpressure in DONE.
        in8 = 8'h01; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_ov", 64'(ov8), 64'd1);
            chk("bp_data", 64'(od8), 64'hFF);
            chk("bp_in_ready", 64'(ir8), 64'd0);
            tick();
        end
        ordy8 = 1'b1;
        tick();
        ordy8 = 1'b0;
        chk("bp_release_ir", 64'(ir8), 64'd1);
        chk("bp_release_ov", 64'(ov8), 64'd0);

        // Abort in RUN at round 1: register keeps the one-round value 8'h03.
        in8 = 8'h01; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick();
        chk("ab_at_r1", 64'(rnd8), 64'd1);
        ab8 = 1'b1;
        tick();
        ab8 = 1'b0;
        chk("ab_ir", 64'(ir8), 64'd1);
        chk("ab_busy", 64'(busy8), 64'd0);
        chk("ab_data_held", 64'(od8), 64'h03);
        tick(); tick();
        chk("ab_no_ov", 64'(ov8), 64'd0);
        job8(8'h01, 8'hFF, "after_ab");

        // Abort in IDLE blocks acceptance.
        in8 = 8'h01; iv8 = 1'b1; ab8 = 1'b1;
        tick();
        iv8 = 1'b0; ab8 = 1'b0;
        chk("ab_idle_busy", 64'(busy8), 64'd0);
        chk("ab_idle_ir", 64'(ir8), 64'd1);

        // rst mid-RUN, with in_valid held during reset.
        in8 = 8'h01; iv8 = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; iv8 = 1'b0;
        chk("rstrun_ir", 64'(ir8), 64'd1);
        chk("rstrun_busy", 64'(busy8), 64'd0);
        chk("rstrun_ov", 64'(ov8), 64'd0);
        chk("rstrun_round", 64'(rnd8), 64'd0);
        chk("rstrun_data", 64'(od8), 64'd0);

        // rst mid-DONE.
        in8 = 8'h01; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        repeat (5) tick();
        chk("rstdone_pre_ov", 64'(ov8), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstdone_ir", 64'(ir8), 64'd1);
        chk("rstdone_ov", 64'(ov8), 64'd0);
        chk("rstdone_round", 64'(rnd8), 64'd0);
        chk("rstdone_data", 64'(od8), 64'd0);

        // N=2048 random vectors vs reference, and involution.
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 64; w++) v[w*32 +: 32] = $urandom;
            r = mref(v);
            job2k(v, r, "n2k_fwd");
            job2k(r, v, "n2k_inv");
        end

        // Back-to-back jobs: accepts must be 13 cycles apart.
        in2k = mref(2048'd1); iv2k = 1'b1; ordy2k = 1'b1;
        for (cyc = 0; cyc < 45; cyc++) begin
            acc = ir2k & iv2k;
            tick();
            if (acc) acc_t.push_back(cyc);
        end
        iv2k = 1'b0; ordy2k = 1'b0;
        chk("b2b_accepts", 64'(acc_t.size() >= 4), 64'd1);
        for (int i = 1; i < acc_t.size(); i++)
            chk("b2b_period", 64'(acc_t[i] - acc_t[i-1]), 64'd13);
        repeat (14) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
